// File: rtl/dma_seq_2940.sv
// DMA transfer sequencer driving an Am2940-style address generator.
// Programs CR, address and word count, then steps the generator once per acknowledged word.
module dma_seq_2940 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] cfg_mode,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_count,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       err,
    output logic [7:0] final_addr,
    output logic [7:0] xfer_cnt,
    output logic       xfer_req,
    input  logic       xfer_ack,
    output logic [2:0] gen_instr,
    output logic [7:0] gen_data,
    output logic       gen_aci,
    output logic       gen_wci,
    input  logic       gen_wco,
    input  logic [7:0] gen_dout
);

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 3;

    localparam logic [IW-1:0] I_WCR  = 3'b000;
    localparam logic [IW-1:0] I_RDA  = 3'b011;
    localparam logic [IW-1:0] I_LADR = 3'b101;
    localparam logic [IW-1:0] I_LWC  = 3'b110;
    localparam logic [IW-1:0] I_EN   = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_WCR, S_LADR, S_LWC, S_REQ, S_STEP, S_CHK, S_RDA, S_CAP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] w_instr;
    logic [DW-1:0] w_data;
    logic          w_en_n;
    logic          w_req;
    logic          w_cnt_match;
    logic          w_abort_hit;

    logic [DW-1:0] r_cfg_addr;
    logic [DW-1:0] r_cfg_count;
    logic [DW-1:0] r_xfer_cnt;
    logic [DW-1:0] r_final_addr;
    logic          r_err_pend;
    logic          r_busy;
    logic          r_done;
    logic          r_aborted;
    logic          r_err;
    logic          r_xfer_req;
    logic [IW-1:0] r_gen_instr;
    logic [DW-1:0] r_gen_data;
    logic          r_gen_en_n;

    assign w_cnt_match = (r_xfer_cnt == r_cfg_count);
    assign w_abort_hit = abort && (r_state != S_IDLE);

    // Next state, then generator/handshake outputs decoded from it so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        w_next  = r_state;
        w_instr = I_EN;
        w_data  = '0;
        w_en_n  = 1'b1;
        w_req   = 1'b0;
        case (r_state)
            S_IDLE:  if (start && !abort) w_next = S_WCR;
            S_WCR:   w_next = S_LADR;
            S_LADR:  w_next = S_LWC;
            S_LWC:   w_next = (r_cfg_count != '0) ? S_REQ : S_RDA;
            S_REQ:   if (xfer_ack) w_next = S_STEP;
            S_STEP:  w_next = S_CHK;
            S_CHK:   w_next = (!gen_wco || w_cnt_match) ? S_RDA : S_REQ;
            S_RDA:   w_next = S_CAP;
            S_CAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort_hit) w_next = S_IDLE;

        case (w_next)
            S_WCR:  begin w_instr = I_WCR;  w_data = DW'(cfg_mode); end
            S_LADR: begin w_instr = I_LADR; w_data = r_cfg_addr;    end
            S_LWC:  begin w_instr = I_LWC;  w_data = r_cfg_count;   end
            S_REQ:  w_req   = 1'b1;
            S_STEP: w_en_n  = 1'b0;
            S_RDA:  w_instr = I_RDA;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cfg_addr   <= '0;
            r_cfg_count  <= '0;
            r_xfer_cnt   <= '0;
            r_final_addr <= '0;
            r_err_pend   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err        <= 1'b0;
            r_xfer_req   <= 1'b0;
            r_gen_instr  <= I_EN;
            r_gen_data   <= '0;
            r_gen_en_n   <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != S_IDLE);
            r_xfer_req  <= w_req;
            r_gen_instr <= w_instr;
            r_gen_data  <= w_data;
            r_gen_en_n  <= w_en_n;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_err       <= 1'b0;
            if (w_abort_hit) begin
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (start && !abort) begin
                        r_cfg_addr  <= cfg_addr;
                        r_cfg_count <= cfg_count;
                        r_xfer_cnt  <= '0;
                        r_err_pend  <= 1'b0;
                    end
                    S_STEP: if (r_xfer_cnt != '1) r_xfer_cnt <= r_xfer_cnt + DW'(1);
                    // Generator terminal count and our own count must agree.
                    S_CHK:  r_err_pend <= (!gen_wco) ^ w_cnt_match;
                    S_CAP: begin
                        r_done       <= 1'b1;
                        r_err        <= r_err_pend;
                        r_final_addr <= gen_dout;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign err        = r_err;
    assign final_addr = r_final_addr;
    assign xfer_cnt   = r_xfer_cnt;
    assign xfer_req   = r_xfer_req;
    assign gen_instr  = r_gen_instr;
    assign gen_data   = r_gen_data;
    assign gen_aci    = r_gen_en_n;
    assign gen_wci    = r_gen_en_n;

endmodule

// File: tb/tb_dma_seq_2940.sv
// Scoreboarded bench for dma_seq_2940 with a behavioural address-generator model.
module tb_dma_seq_2940;

    logic       clk = 1'b0;
    logic       rst, start, abort, xfer_ack;
    logic [2:0] cfg_mode;
    logic [7:0] cfg_addr, cfg_count;
    logic       busy, done, aborted, err, xfer_req, gen_aci, gen_wci, gen_wco;
    logic [7:0] final_addr, xfer_cnt, gen_data, gen_dout;
    logic [2:0] gen_instr;

    dma_seq_2940 dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .busy(busy), .done(done), .aborted(aborted), .err(err),
        .final_addr(final_addr), .xfer_cnt(xfer_cnt),
        .xfer_req(xfer_req), .xfer_ack(xfer_ack),
        .gen_instr(gen_instr), .gen_data(gen_data),
        .gen_aci(gen_aci), .gen_wci(gen_wci),
        .gen_wco(gen_wco), .gen_dout(gen_dout)
    );

    always #5 clk = ~clk;

    // Address generator: address counter, step counter, wco low once enough steps taken.
    logic [7:0] g_addr  = 8'h00;
    int         g_steps = 0;
    int         g_wco_at = 255;
    always @(posedge clk) begin
        case (gen_instr)
            3'b101: g_addr <= gen_data;
            3'b110: g_steps <= 0;
            3'b111: begin
                if (!gen_aci) g_addr <= g_addr + 8'd1;
                if (!gen_wci) g_steps <= g_steps + 1;
            end
            default: ;
        endcase
    end
    assign gen_dout = g_addr;
    assign gen_wco  = !(g_steps >= g_wco_at);

    typedef struct {
        bit         is_abort;
        bit         err;
        logic [7:0] cnt;
        logic [7:0] fa;
        int         steps;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] last_fa = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("reset ctrl", {busy, done, aborted, err, xfer_req, gen_aci, gen_wci, gen_instr},
            {5'b00000, 2'b11, 3'b111});
        chk("reset final_addr", final_addr, 0);
        chk("reset xfer_cnt", xfer_cnt, 0);
        chk("reset gen_data", gen_data, 0);
    endtask

    // Monitor: pops the expectation whenever a transfer ends.
    int steps_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (gen_instr == 3'b000) steps_seen = 0;
        if (!gen_aci) steps_seen++;
        if (err && !done) chk("err without done", {err, done}, 2'b00);
        if (done || aborted) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected completion: done=%0b aborted=%0b", done, aborted);
            end else begin
                e = q.pop_front();
                chk("aborted", aborted, e.is_abort);
                chk("done", done, !e.is_abort);
                chk("err", err, e.err);
                chk("busy at end", busy, 0);
                chk("xfer_cnt", xfer_cnt, e.cnt);
                chk("final_addr", final_addr, e.fa);
                chk("step pulses", steps_seen, e.steps);
            end
        end
    end

    // One transfer. ab_at<0: no abort; dly<1: random ack delay; dir: cycle-level checks.
    task automatic run(input logic [2:0] m, input logic [7:0] a, input logic [7:0] c,
                       input int w, input int ab_at, input int dly,
                       input bit rst_step, input bit dir);
        exp_t e;
        int   n, cyc, words, req_run, need;
        bit   is_ab, first;
        n     = (c == 0) ? 0 : ((int'(c) < w) ? int'(c) : w);
        is_ab = (ab_at >= 0) && (ab_at < n);
        if (is_ab) begin
            e = '{1'b1, 1'b0, 8'(ab_at), last_fa, ab_at};
        end else begin
            e.is_abort = 1'b0;
            e.err      = (c != 0) && ((n == int'(c)) != (n >= w));
            e.cnt      = 8'(n);
            e.fa       = a + 8'(n);
            e.steps    = n;
        end
        if (!rst_step) begin
            q.push_back(e);
            if (!is_ab) last_fa = e.fa;
        end
        g_wco_at  = w;
        cfg_mode  = m;
        cfg_addr  = a;
        cfg_count = c;
        start     = 1'b1;
        abort     = 1'b0;
        xfer_ack  = 1'b0;
        cyc = 0; words = 0; req_run = 0; first = 1'b1;
        need = (dly >= 1) ? dly : int'($urandom_range(1, 3));
        forever begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            xfer_ack  = 1'b0;
            abort     = 1'b0;
            cfg_mode  = 3'($urandom);
            cfg_addr  = 8'($urandom);
            cfg_count = 8'($urandom);
            if (dir) begin
                case (cyc)
                    1: begin
                        chk("WCR instr", gen_instr, 3'b000);
                        chk("WCR data", gen_data, m);
                        chk("busy after start", busy, 1);
                        chk("xfer_cnt cleared", xfer_cnt, 0);
                    end
                    2: begin chk("LADR instr", gen_instr, 3'b101); chk("LADR data", gen_data, a); end
                    3: begin chk("LWC instr", gen_instr, 3'b110); chk("LWC data", gen_data, c); end
                    4: chk("REQ entry", xfer_req, (c != 0));
                    default: ;
                endcase
            end
            if (done || aborted) begin
                if (dir && c == 0) chk("zero-count done latency", cyc, 6);
                break;
            end
            if (rst_step && !gen_aci) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                last_fa = 8'h00;
                chk_reset_outputs();
                break;
            end
            if (xfer_req) begin
                req_run++;
                if (dir) chk("enables idle during REQ", {gen_aci, gen_wci}, 2'b11);
                if (is_ab && words == ab_at) begin
                    abort    = 1'b1;
                    xfer_ack = 1'($urandom);
                end else if (req_run >= need) begin
                    xfer_ack = 1'b1;
                    if (dir && first) chk("xfer_req hold cycles", req_run, need);
                    first   = 1'b0;
                    words++;
                    req_run = 0;
                    need    = (dly >= 1) ? dly : int'($urandom_range(1, 3));
                end
            end else begin
                xfer_ack = ($urandom_range(0, 3) == 0);
            end
            if (cyc > 300) begin
                n_vec++;
                n_bad++;
                $display("FAIL transfer timeout: busy=%0b after %0d cycles", busy, cyc);
                break;
            end
        end
        xfer_ack = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; xfer_ack = 1'b0;
        cfg_mode = '0; cfg_addr = '0; cfg_count = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs();

        // start together with abort in IDLE is not accepted
        start = 1'b1; abort = 1'b1; cfg_count = 8'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start+abort ignored", {busy, gen_instr}, {1'b0, 3'b111});

        run(3'b010, 8'h02, 8'h03, 3, -1, 1, 1'b0, 1'b1);   // normal 3-word sequence
        run(3'b001, 8'h40, 8'h00, 255, -1, 1, 1'b0, 1'b1); // zero count
        run(3'b001, 8'h10, 8'h02, 2, -1, 4, 1'b0, 1'b1);   // ack delayed 4 cycles
        run(3'b000, 8'h20, 8'h03, 3, 1, 1, 1'b0, 1'b1);    // abort in REQ after 1 word
        run(3'b000, 8'h30, 8'h04, 1, -1, 1, 1'b0, 1'b1);   // wco early -> err
        run(3'b000, 8'h50, 8'h03, 3, -1, 1, 1'b1, 1'b1);   // reset during STEP
        run(3'b110, 8'h60, 8'h02, 2, -1, 1, 1'b0, 1'b1);   // full sequence after reset

        for (int i = 0; i < 30; i++) begin
            int w;
            w = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(1, 8));
            run(3'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), w,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
                0, 1'b0, 1'b0);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("pending expectations", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_seq_2940.md
DMA_SEQ_2940 -- requirements
Module: dma_seq_2940

Interface
REQ-001 Parameter: none; all widths fixed (8-bit data/address, 3-bit instruction).
REQ-002 One clock; reset is synchronous and active-high. Ports are clk and rst; all state changes on rising clk.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request a transfer; sampled only in IDLE.
REQ-006 abort  in  1  terminate the current transfer.
REQ-007 cfg_mode  in  3  value for the generator control register (CR).
REQ-008 cfg_addr  in  8  start address.
REQ-009 cfg_count  in  8  word count; 0 means no transfer.
REQ-010 busy  out  1  high from the cycle after start acceptance until return to IDLE.
REQ-011 done  out  1  one-cycle pulse on normal completion.
REQ-012 aborted  out  1  one-cycle pulse on abort.
REQ-013 err  out  1  one-cycle pulse, coincident with done, on a count mismatch.
REQ-014 final_addr  out  8  address-counter value captured at completion.
REQ-015 xfer_cnt  out  8  words transferred in the current or last transfer.
REQ-016 xfer_req  out  1  memory-side word request.
REQ-017 xfer_ack  in  1  memory-side word acknowledge.
REQ-018 gen_instr  out  3  instruction to the address generator.
REQ-019 gen_data  out  8  generator data input.
REQ-020 gen_aci, gen_wci  out  1  generator count enables, active-low.
REQ-021 gen_wco  in  1  generator word-count carry out, active-low at terminal count.
REQ-022 gen_dout  in  8  generator data output.

Function
REQ-023 Generator codes: 000 write CR; 011 read address counter; 101 load address; 110 load word count; 111 enable counters.
REQ-024 FSM states SHALL be IDLE, WCR, LADR, LWC, REQ, STEP, CHK, RDA, CAP.
REQ-025 IDLE: gen_instr=111, gen_aci=gen_wci=1, xfer_req=0. If start=1 and abort=0, go to WCR and clear xfer_cnt.
REQ-026 WCR: gen_instr=000, gen_data=cfg_mode, 1 cycle, then LADR.
REQ-027 LADR: gen_instr=101, gen_data=cfg_addr, 1 cycle, then LWC.
REQ-028 LWC: gen_instr=110, gen_data=cfg_count, 1 cycle, then REQ if cfg_count!=0, else RDA.
REQ-029 cfg_* SHALL be registered at start acceptance; changes to cfg_* during busy have no effect.
REQ-030 REQ: gen_instr=111, xfer_req=1, held until xfer_ack=1. On xfer_ack, go to STEP.
REQ-031 STEP: gen_instr=111, gen_aci=gen_wci=0 for exactly 1 cycle, xfer_req=0, xfer_cnt+1. Then go to CHK.
REQ-032 CHK: gen_instr=111, enables high. Next state:
- RDA if gen_wco=0 or xfer_cnt==latched cfg_count;
- otherwise REQ.
REQ-033 err SHALL be flagged if CHK exits with gen_wco=0 XOR xfer_cnt==cfg_count.
REQ-034 RDA: gen_instr=011, 1 cycle, then CAP.
REQ-035 CAP: final_addr<=gen_dout; done=1 (and err if flagged); next state IDLE.
REQ-036 Latency: start at edge k -> WCR at k+1, REQ at k+4. Zero count: done at k+6.
REQ-037 abort=1 in any non-IDLE state: next state IDLE, aborted=1, done=0. final_addr and xfer_cnt are held.
REQ-038 abort has priority over xfer_ack and start in the same cycle.
REQ-039 xfer_cnt SHALL saturate at 255 and never wrap.
REQ-040 xfer_ack outside REQ SHALL be ignored.

Reset
REQ-041 On rst=1 at a rising edge: state IDLE; busy, done, aborted, err and xfer_req = 0.
REQ-042 On reset: final_addr=0, xfer_cnt=0, gen_instr=111, gen_data=0, gen_aci=gen_wci=1.
REQ-043 rst mid-transfer SHALL abandon the transfer without an aborted pulse. rst overrides all inputs.

Verification
REQ-044 Sequence check:
- stimulus: cfg_mode=010, cfg_addr=02, cfg_count=03, start, immediate acks, generator model wco=0 after 3rd step;
- required: gen_instr 000,101,110 on consecutive cycles; 3 STEP pulses; xfer_cnt=3; final_addr=05; done=1, err=0.
REQ-045 Zero count: cfg_count=0, start -> no xfer_req; done 6 cycles after start; xfer_cnt=0.
REQ-046 Ack wait: ack delayed 4 cycles -> xfer_req held 4 cycles; gen_aci/gen_wci stay 1 until ack.
REQ-047 Abort in REQ after 1 word -> aborted pulse, busy=0 next cycle, xfer_cnt=1, done never asserted.
REQ-048 Mismatch: model asserts wco=0 after word 1, cfg_count=04 -> done and err together, xfer_cnt=1.
REQ-049 Reset during STEP -> next cycle all outputs at reset values; a new start runs a full normal sequence.
